// File: rtl/vga_draw_sched.sv
// rtl/vga_draw_sched.sv - block-drawing scheduler feeding the VGA adapter plot port
//
// Purpose:
//   Arbitrates pointer and piece draw requests, then walks a BLK x BLK pixel
//   square per grant and emits one registered pixel per cycle. A pointer move
//   first erases the square at the previously drawn pointer column.
//
// Ports:
//   clk, resetn        clock; synchronous active-low reset
//   i_ptr_req          level request to (re)draw the pointer, held until o_ptr_ack
//   i_ptr_col          target pointer column
//   i_ptr_player       pointer colour select (0 red, 1 yellow)
//   i_piece_req        level request to draw a piece, held until o_piece_ack
//   i_piece_col        piece column
//   i_piece_row        piece row (0 = top)
//   i_piece_player     piece colour select
//   o_ptr_ack          one-cycle grant pulse for the pointer
//   o_piece_ack        one-cycle grant pulse for the piece
//   o_busy             high whenever a job is in progress
//   o_done             one-cycle pulse when a granted job completes
//   o_x, o_y           pixel coordinates
//   o_colour           pixel colour (RGB)
//   o_plot             pixel write enable
module vga_draw_sched #(
  parameter int unsigned BLK   = 4,
  parameter int unsigned COLS  = 7,
  parameter int unsigned ROWS  = 6,
  parameter logic [7:0]  X_ORG = 8'd40,
  parameter logic [6:0]  Y_ORG = 7'd20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_ptr_req,
  input  logic [2:0] i_ptr_col,
  input  logic       i_ptr_player,
  input  logic       i_piece_req,
  input  logic [2:0] i_piece_col,
  input  logic [2:0] i_piece_row,
  input  logic       i_piece_player,
  output logic       o_ptr_ack,
  output logic       o_piece_ack,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_x,
  output logic [6:0] o_y,
  output logic [2:0] o_colour,
  output logic       o_plot
);

  localparam int unsigned LW = $clog2(BLK);
  localparam int unsigned CW = 2 * LW;
  localparam logic [CW-1:0] LAST = CW'(BLK * BLK - 1);
  localparam logic [3:0] COLS_W = 4'(COLS);
  localparam logic [3:0] ROWS_W = 4'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE_PTR,
    S_DRAW_PTR,
    S_DRAW_PIECE,
    S_FIN
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_col;
  logic [2:0]    r_row;
  logic          r_player;
  logic [2:0]    r_old_col;
  logic          r_valid;
  logic [7:0]    r_x;
  logic [6:0]    r_y;
  logic [2:0]    r_colour;
  logic          r_plot;

  state_t        w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic [2:0]    w_nxt_col;
  logic [2:0]    w_nxt_row;
  logic          w_nxt_player;
  logic [2:0]    w_nxt_old_col;
  logic          w_nxt_valid;
  logic          w_ptr_ack;
  logic          w_piece_ack;
  logic          w_piece_oor;
  logic          w_ptr_oor;

  logic [2:0]    w_pix_col;
  logic [6:0]    w_row1;
  logic [6:0]    w_base_y;
  logic [7:0]    w_pix_x;
  logic [6:0]    w_pix_y;
  logic [2:0]    w_pix_colour;
  logic          w_pix_plot;

  assign w_piece_oor = ({1'b0, i_piece_col} >= COLS_W) || ({1'b0, i_piece_row} >= ROWS_W);
  assign w_ptr_oor   = ({1'b0, i_ptr_col} >= COLS_W);

  // Next-state, request arbitration and job bookkeeping
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_cnt     = r_cnt;
    w_nxt_col     = r_col;
    w_nxt_row     = r_row;
    w_nxt_player  = r_player;
    w_nxt_old_col = r_old_col;
    w_nxt_valid   = r_valid;
    w_ptr_ack     = 1'b0;
    w_piece_ack   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_piece_req) begin
          w_piece_ack  = 1'b1;
          w_nxt_col    = i_piece_col;
          w_nxt_row    = i_piece_row;
          w_nxt_player = i_piece_player;
          w_nxt_cnt    = '0;
          w_nxt_state  = w_piece_oor ? S_FIN : S_DRAW_PIECE;
        end else if (i_ptr_req) begin
          w_ptr_ack    = 1'b1;
          w_nxt_col    = i_ptr_col;
          w_nxt_player = i_ptr_player;
          w_nxt_cnt    = '0;
          if (w_ptr_oor)    w_nxt_state = S_FIN;
          else if (r_valid) w_nxt_state = S_ERASE_PTR;
          else              w_nxt_state = S_DRAW_PTR;
        end
      end
      S_ERASE_PTR: begin
        if (r_cnt == LAST) begin
          w_nxt_state = S_DRAW_PTR;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      S_DRAW_PTR: begin
        if (r_cnt == LAST) begin
          w_nxt_state   = S_FIN;
          w_nxt_cnt     = '0;
          // The square now on screen is what the next move must erase
          w_nxt_old_col = r_col;
          w_nxt_valid   = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      S_DRAW_PIECE: begin
        if (r_cnt == LAST) begin
          w_nxt_state = S_FIN;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      S_FIN: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // Pixel generation looks at the next state/counter so the registered
  // outputs line up with the phase the FSM is in; first plot follows ack.
  always_comb begin
    w_pix_col    = (w_nxt_state == S_ERASE_PTR) ? w_nxt_old_col : w_nxt_col;
    w_row1       = {4'd0, w_nxt_row} + 7'd1;
    w_base_y     = (w_nxt_state == S_DRAW_PIECE) ? (Y_ORG + (w_row1 << LW)) : Y_ORG;
    w_pix_x      = X_ORG + ({5'd0, w_pix_col} << LW) + {{(8-LW){1'b0}}, w_nxt_cnt[LW-1:0]};
    w_pix_y      = w_base_y + {{(7-LW){1'b0}}, w_nxt_cnt[CW-1:LW]};
    w_pix_colour = (w_nxt_state == S_ERASE_PTR) ? 3'b000 :
                   (w_nxt_player ? 3'b110 : 3'b100);
    w_pix_plot   = (w_nxt_state == S_ERASE_PTR) || (w_nxt_state == S_DRAW_PTR) ||
                   (w_nxt_state == S_DRAW_PIECE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_col     <= '0;
      r_row     <= '0;
      r_player  <= 1'b0;
      r_old_col <= '0;
      r_valid   <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_colour  <= '0;
      r_plot    <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_col     <= w_nxt_col;
      r_row     <= w_nxt_row;
      r_player  <= w_nxt_player;
      r_old_col <= w_nxt_old_col;
      r_valid   <= w_nxt_valid;
      r_plot    <= w_pix_plot;
      if (w_pix_plot) begin
        r_x      <= w_pix_x;
        r_y      <= w_pix_y;
        r_colour <= w_pix_colour;
      end
    end
  end

  // Acks are combinational so they pulse in the cycle the request is sampled;
  // masked while reset is held so nothing is granted that will not be served.
  assign o_ptr_ack   = w_ptr_ack & resetn;
  assign o_piece_ack = w_piece_ack & resetn;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_FIN);
  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_colour    = r_colour;
  assign o_plot      = r_plot;

endmodule

// File: tb/tb_vga_draw_sched.sv
// tb/tb_vga_draw_sched.sv - self-checking bench for vga_draw_sched
module tb_vga_draw_sched;

  logic       clk = 1'b0;
  logic       resetn;
  logic       i_ptr_req;
  logic [2:0] i_ptr_col;
  logic       i_ptr_player;
  logic       i_piece_req;
  logic [2:0] i_piece_col;
  logic [2:0] i_piece_row;
  logic       i_piece_player;
  logic       o_ptr_ack;
  logic       o_piece_ack;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_x;
  logic [6:0] o_y;
  logic [2:0] o_colour;
  logic       o_plot;

  always #5 clk = ~clk;

  vga_draw_sched dut (
    .clk            (clk),
    .resetn         (resetn),
    .i_ptr_req      (i_ptr_req),
    .i_ptr_col      (i_ptr_col),
    .i_ptr_player   (i_ptr_player),
    .i_piece_req    (i_piece_req),
    .i_piece_col    (i_piece_col),
    .i_piece_row    (i_piece_row),
    .i_piece_player (i_piece_player),
    .o_ptr_ack      (o_ptr_ack),
    .o_piece_ack    (o_piece_ack),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_x            (o_x),
    .o_y            (o_y),
    .o_colour       (o_colour),
    .o_plot         (o_plot)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pointer memory plus the list of pixels a job must emit
  logic        m_valid;
  logic [2:0]  m_old_col;
  logic [17:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [2:0] pcolour(input logic p);
    return p ? 3'b110 : 3'b100;
  endfunction

  task automatic push_block(input int col, input int basey, input logic [2:0] c);
    logic [7:0] xv;
    logic [6:0] yv;
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        xv = 8'(40 + col * 4 + dx);
        yv = 7'(basey + dy);
        exp_q.push_back({xv, yv, c});
      end
    end
  endtask

  task automatic build_ptr(input int col, input logic p);
    exp_q.delete();
    if (col < 7) begin
      if (m_valid) push_block(int'(m_old_col), 20, 3'b000);
      push_block(col, 20, pcolour(p));
      m_valid   = 1'b1;
      m_old_col = 3'(col);
    end
  endtask

  task automatic build_piece(input int col, input int row, input logic p);
    exp_q.delete();
    if (col < 7 && row < 6) push_block(col, 20 + 4 * (row + 1), pcolour(p));
  endtask

  // Checks every expected pixel, then the FIN cycle, then the return to IDLE
  task automatic run_stream(input string tag, input bit keep_ptr);
    foreach (exp_q[i]) begin
      chk($sformatf("%s px%0d", tag, i),
          {9'd0, o_plot, o_busy, o_done, o_ptr_ack, o_piece_ack, o_x, o_y, o_colour},
          {9'd0, 5'b11000, exp_q[i]});
      tick();
    end
    chk({tag, " fin"}, 32'({o_plot, o_busy, o_done, o_ptr_ack, o_piece_ack}), 32'(5'b01100));
    i_piece_req = 1'b0;
    if (!keep_ptr) i_ptr_req = 1'b0;
    tick();
    chk({tag, " idle"}, 32'({o_plot, o_busy, o_done}), 32'(3'b000));
  endtask

  task automatic do_ptr(input string tag, input int col, input logic p, input bit hold);
    i_ptr_req    = 1'b1;
    i_ptr_col    = 3'(col);
    i_ptr_player = p;
    #1;
    chk({tag, " ack"}, 32'({o_ptr_ack, o_piece_ack}), 32'(2'b10));
    build_ptr(col, p);
    tick();
    if (!hold) i_ptr_req = 1'b0;
    i_ptr_col    = 3'($urandom);
    i_ptr_player = 1'($urandom);
    run_stream(tag, 1'b0);
  endtask

  task automatic do_piece(input string tag, input int col, input int row, input logic p, input bit hold);
    i_piece_req    = 1'b1;
    i_piece_col    = 3'(col);
    i_piece_row    = 3'(row);
    i_piece_player = p;
    #1;
    chk({tag, " ack"}, 32'({o_ptr_ack, o_piece_ack}), 32'(2'b01));
    build_piece(col, row, p);
    tick();
    if (!hold) i_piece_req = 1'b0;
    i_piece_col    = 3'($urandom);
    i_piece_row    = 3'($urandom);
    i_piece_player = 1'($urandom);
    run_stream(tag, 1'b0);
  endtask

  initial begin
    resetn         = 1'b0;
    i_ptr_req      = 1'b1;
    i_ptr_col      = 3'd3;
    i_ptr_player   = 1'b0;
    i_piece_req    = 1'b0;
    i_piece_col    = 3'd0;
    i_piece_row    = 3'd0;
    i_piece_player = 1'b0;
    m_valid        = 1'b0;
    m_old_col      = 3'd0;
    tick();
    tick();
    chk("reset state",
        {9'd0, o_busy, o_done, o_plot, o_ptr_ack, o_piece_ack, o_x, o_y, o_colour}, 32'd0);
    i_ptr_req = 1'b0;
    resetn    = 1'b1;
    tick();

    // First pointer draw, then a move that erases the old square
    do_ptr("t1 first ptr", 2, 1'b0, 1'b0);
    do_ptr("t2 ptr move", 5, 1'b0, 1'b0);

    // Simultaneous requests: piece wins, pointer served right after FIN
    i_piece_req    = 1'b1;
    i_piece_col    = 3'd3;
    i_piece_row    = 3'd5;
    i_piece_player = 1'b1;
    i_ptr_req      = 1'b1;
    i_ptr_col      = 3'd1;
    i_ptr_player   = 1'b1;
    #1;
    chk("t3 piece wins", 32'({o_ptr_ack, o_piece_ack}), 32'(2'b01));
    build_piece(3, 5, 1'b1);
    tick();
    i_piece_req = 1'b0;
    run_stream("t3 piece", 1'b1);
    chk("t3 ptr after fin", 32'({o_ptr_ack, o_piece_ack}), 32'(2'b10));
    build_ptr(1, 1'b1);
    tick();
    i_ptr_req = 1'b0;
    run_stream("t3 ptr", 1'b0);

    // Out-of-range requests leave pointer state untouched
    do_piece("t4 piece col7", 7, 2, 1'b0, 1'b0);
    do_piece("t4 piece row6", 2, 6, 1'b1, 1'b0);
    do_ptr("t4 ptr col7", 7, 1'b1, 1'b0);
    do_ptr("t4 ptr after oor", 4, 1'b0, 1'b0);
    do_ptr("t4 same col", 4, 1'b1, 1'b0);

    // Reset during the 8th pixel of the draw phase of a pointer move
    i_ptr_req    = 1'b1;
    i_ptr_col    = 3'd6;
    i_ptr_player = 1'b0;
    #1;
    chk("t5 ack", 32'({o_ptr_ack, o_piece_ack}), 32'(2'b10));
    build_ptr(6, 1'b0);
    tick();
    i_ptr_req = 1'b0;
    for (int i = 0; i < 23; i++) begin
      chk($sformatf("t5 px%0d", i),
          {9'd0, o_plot, o_busy, o_done, o_ptr_ack, o_piece_ack, o_x, o_y, o_colour},
          {9'd0, 5'b11000, exp_q[i]});
      tick();
    end
    chk("t5 px23", {14'd0, o_x, o_y, o_colour}, {14'd0, exp_q[23]});
    resetn = 1'b0;
    tick();
    chk("t5 abort", 32'({o_plot, o_busy, o_done}), 32'(3'b000));
    resetn  = 1'b1;
    m_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5 quiet%0d", i), 32'({o_plot, o_busy, o_done}), 32'(3'b000));
    end
    do_ptr("t5 redraw", 3, 1'b1, 1'b0);

    // Requests held high through the whole job are acked exactly once
    do_ptr("t6 hold ptr", 2, 1'b1, 1'b1);
    do_piece("t6 hold piece", 0, 0, 1'b0, 1'b1);
    do_ptr("t6 hold oor", 7, 1'b0, 1'b1);

    // Random jobs against the model
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(1, 0) == 1)
        do_piece($sformatf("r%0d piece", n), int'($urandom_range(7, 0)),
                 int'($urandom_range(7, 0)), 1'($urandom), 1'($urandom));
      else
        do_ptr($sformatf("r%0d ptr", n), int'($urandom_range(7, 0)),
               1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
